pong_score: RTL

PONG_SCORE -- requirements
Module: pong_score

---
 rtl/pong_pkg.sv | 35 +++
 rtl/seg7_font.sv | 35 +++
 rtl/pong_score.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants and types for the Pong score block.
//                Holds the screen resolution, the score-digit origins, the
//                seven-segment type and the score state machine encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Active display area
    localparam int c_H_RES = 640;
    localparam int c_V_RES = 480;

    // Top-left pixel of each score digit
    localparam int c_P1_X = 256;
    localparam int c_P1_Y = 16;
    localparam int c_P2_X = 360;
    localparam int c_P2_Y = 16;

    // Seven-segment pattern, segment a in bit 6 down to segment g in bit 0
    typedef logic [6:0] seg7_t;

    // Score state machine encoding
    localparam logic [0:0] c_ST_PLAY = 1'b0;
    localparam logic [0:0] c_ST_WON  = 1'b1;

    typedef enum logic [0:0] {
        ST_PLAY = c_ST_PLAY,
        ST_WON  = c_ST_WON
    } score_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_font.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_font
//  Description : Combinational BCD to seven-segment decode. Codes above 9
//                light nothing.
//  Ports       : i_bcd [3:0] - BCD digit in
//                o_seg [6:0] - segment pattern out (a = bit 6 .. g = bit 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_font
    import pong_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg7_t      o_seg
);

    always_comb begin
        o_seg = 7'b000_0000;
        case (i_bcd)
            4'd0:    o_seg = 7'b111_1110;
            4'd1:    o_seg = 7'b011_0000;
            4'd2:    o_seg = 7'b110_1101;
            4'd3:    o_seg = 7'b111_1001;
            4'd4:    o_seg = 7'b011_0011;
            4'd5:    o_seg = 7'b101_1011;
            4'd6:    o_seg = 7'b101_1111;
            4'd7:    o_seg = 7'b111_0000;
            4'd8:    o_seg = 7'b111_1111;
            4'd9:    o_seg = 7'b111_1011;
            default: o_seg = 7'b000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pong_score.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score
//  Description : Pong score keeping and score-digit rendering. Counts points
//                on rising edges of the ball-out levels, ends the game when a
//                score reaches WIN_SCORE and draws both scores as 3x5-cell
//                seven-segment digits.
//                Define SCORE_FLASH_EN to flash the winner's digit (32 frames
//                lit, 32 frames blank) once a game is won.
//  Ports       : clk_pix          - pixel clock
//                rst_n            - asynchronous reset, active low
//                sx, sy           - current pixel coordinates
//                frame            - start-of-vertical-blanking strobe
//                pt_lft, pt_rgt   - ball at left / right edge (levels)
//                clear            - start a new game
//                score_p1/_p2     - BCD scores
//                game_over        - a player has reached WIN_SCORE
//                winner           - 0 = player 1, 1 = player 2
//                s_draw           - current pixel is on a lit segment (1 clk late)
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_score
    import pong_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int WIN_SCORE = 9,
    parameter int CELL      = 8
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             frame,
    input  logic             pt_lft,
    input  logic             pt_rgt,
    input  logic             clear,
    output logic [3:0]       score_p1,
    output logic [3:0]       score_p2,
    output logic             game_over,
    output logic             winner,
    output logic             s_draw
);

    localparam logic [3:0]       c_WIN   = 4'(WIN_SCORE);
    localparam int               c_SHIFT = $clog2(CELL);
    localparam logic [CORDW-1:0] c_P1_X0 = CORDW'(c_P1_X);
    localparam logic [CORDW-1:0] c_P1_X1 = CORDW'(c_P1_X + 3 * CELL);
    localparam logic [CORDW-1:0] c_P1_Y0 = CORDW'(c_P1_Y);
    localparam logic [CORDW-1:0] c_P1_Y1 = CORDW'(c_P1_Y + 5 * CELL);
    localparam logic [CORDW-1:0] c_P2_X0 = CORDW'(c_P2_X);
    localparam logic [CORDW-1:0] c_P2_X1 = CORDW'(c_P2_X + 3 * CELL);
    localparam logic [CORDW-1:0] c_P2_Y0 = CORDW'(c_P2_Y);
    localparam logic [CORDW-1:0] c_P2_Y1 = CORDW'(c_P2_Y + 5 * CELL);

    // ------------------------------------------------------------------
    // Point edge detection. r_armed stays low for the first clock after
    // reset so a level that is already high at release is only sampled,
    // never counted.
    // ------------------------------------------------------------------
    logic r_lft_q, r_rgt_q, r_armed;
    logic w_ev_lft, w_ev_rgt;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_q <= 1'b0;
            r_rgt_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_lft_q <= pt_lft;
            r_rgt_q <= pt_rgt;
            r_armed <= 1'b1;
        end
    end

    assign w_ev_lft = r_armed && pt_lft && !r_lft_q;
    assign w_ev_rgt = r_armed && pt_rgt && !r_rgt_q;

    // ------------------------------------------------------------------
    // Score state machine. Simultaneous events cancel; scores stop at
    // WIN_SCORE because reaching it moves to ST_WON, where events are
    // ignored.
    // ------------------------------------------------------------------
    score_state_t r_state;
    logic [3:0]   r_p1, r_p2;
    logic         r_winner;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_PLAY;
            r_p1     <= 4'd0;
            r_p2     <= 4'd0;
            r_winner <= 1'b0;
        end else if (clear) begin
            r_state  <= ST_PLAY;
            r_p1     <= 4'd0;
            r_p2     <= 4'd0;
            r_winner <= 1'b0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_ev_rgt && !w_ev_lft) begin
                        r_p1 <= r_p1 + 4'd1;
                        if (r_p1 + 4'd1 == c_WIN) begin
                            r_state  <= ST_WON;
                            r_winner <= 1'b0;
                        end
                    end else if (w_ev_lft && !w_ev_rgt) begin
                        r_p2 <= r_p2 + 4'd1;
                        if (r_p2 + 4'd1 == c_WIN) begin
                            r_state  <= ST_WON;
                            r_winner <= 1'b1;
                        end
                    end
                end
                ST_WON: begin
                    r_state <= ST_WON;
                end
                default: r_state <= ST_PLAY;
            endcase
        end
    end

    assign score_p1  = r_p1;
    assign score_p2  = r_p2;
    assign game_over = (r_state == ST_WON);
    assign winner    = r_winner;

    // ------------------------------------------------------------------
    // Winner flash
    // ------------------------------------------------------------------
    logic w_blank_p1, w_blank_p2;

`ifdef SCORE_FLASH_EN
    logic [5:0] r_flash;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_flash <= 6'd0;
        end else if (clear) begin
            r_flash <= 6'd0;
        end else if (frame) begin
            r_flash <= r_flash + 6'd1;
        end
    end

    assign w_blank_p1 = (r_state == ST_WON) && !r_winner && r_flash[5];
    assign w_blank_p2 = (r_state == ST_WON) &&  r_winner && r_flash[5];
`else
    logic w_frame_unused;
    assign w_frame_unused = frame;
    assign w_blank_p1     = 1'b0;
    assign w_blank_p2     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Digit rendering
    // ------------------------------------------------------------------
    seg7_t w_seg_p1, w_seg_p2;

    seg7_font u_font_p1 (.i_bcd(r_p1), .o_seg(w_seg_p1));
    seg7_font u_font_p2 (.i_bcd(r_p2), .o_seg(w_seg_p2));

    // Lit test for one cell of the 3x5 grid. Row 2 is shared by the upper
    // and lower vertical segments.
    function automatic logic cell_lit(input seg7_t seg,
                                      input logic [CORDW-1:0] col,
                                      input logic [CORDW-1:0] row);
        logic l_left, l_right, l_upper, l_lower;
        l_left   = (col == CORDW'(0));
        l_right  = (col == CORDW'(2));
        l_upper  = (row <= CORDW'(2));
        l_lower  = (row >= CORDW'(2));
        cell_lit = (seg[6] && row == CORDW'(0))
                 | (seg[5] && l_right && l_upper)
                 | (seg[4] && l_right && l_lower)
                 | (seg[3] && row == CORDW'(4))
                 | (seg[2] && l_left && l_lower)
                 | (seg[1] && l_left && l_upper)
                 | (seg[0] && row == CORDW'(2));
    endfunction

    logic             w_on_screen, w_p1_box, w_p2_box;
    logic [CORDW-1:0] w_p1_col, w_p1_row, w_p2_col, w_p2_row;
    logic             r_s_draw;

    assign w_on_screen = (sx < CORDW'(c_H_RES)) && (sy < CORDW'(c_V_RES));
    assign w_p1_box    = (sx >= c_P1_X0) && (sx < c_P1_X1) && (sy >= c_P1_Y0) && (sy < c_P1_Y1);
    assign w_p2_box    = (sx >= c_P2_X0) && (sx < c_P2_X1) && (sy >= c_P2_Y0) && (sy < c_P2_Y1);

    // Division by CELL; offsets are only meaningful inside the box
    assign w_p1_col = (sx - c_P1_X0) >> c_SHIFT;
    assign w_p1_row = (sy - c_P1_Y0) >> c_SHIFT;
    assign w_p2_col = (sx - c_P2_X0) >> c_SHIFT;
    assign w_p2_row = (sy - c_P2_Y0) >> c_SHIFT;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_s_draw <= 1'b0;
        end else begin
            r_s_draw <= w_on_screen &&
                        ((w_p1_box && !w_blank_p1 && cell_lit(w_seg_p1, w_p1_col, w_p1_row)) ||
                         (w_p2_box && !w_blank_p2 && cell_lit(w_seg_p2, w_p2_col, w_p2_row)));
        end
    end

    assign s_draw = r_s_draw;

endmodule
`default_nettype wire
